// File: rtl/board_scan_ctrl.sv
// Scans an 8x8 reed-switch matrix one row at a time and publishes a debounced
// 64-bit board image; the image stays frozen while o_done is high until i_ack.
module board_scan_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_SCANS  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_col_in,
  input  logic        i_ack,
  output logic [7:0]  o_row_sel,
  output logic [63:0] o_board_state,
  output logic        o_done,
  output logic        o_scan_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRIVE   = 3'd1;
  localparam logic [2:0] S_SAMPLE  = 3'd2;
  localparam logic [2:0] S_NEXT    = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;

  localparam int              CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      STABLE_MAX  = 4'(STABLE_SCANS);

  logic [2:0]    r_state;
  logic [2:0]    r_row;
  logic [CW-1:0] r_settle;
  logic [7:0]    r_col_s1;
  logic [7:0]    r_col_s2;
  logic [63:0]   r_scan_buf;
  logic [63:0]   r_prev_scan;
  logic [63:0]   r_board_state;
  logic [3:0]    r_stable_cnt;
  logic          r_first_pub;
  logic          r_done;

  logic [7:0]    w_row_onehot;
  logic [3:0]    w_cnt_nxt;
  logic          w_publish;

  assign w_row_onehot  = 8'h01 << r_row;
  // Row is released during NEXT so two rows are never driven together.
  assign o_row_sel     = ((r_state == S_DRIVE) || (r_state == S_SAMPLE)) ? w_row_onehot : 8'h00;
  assign o_board_state = r_board_state;
  assign o_done        = r_done;
  assign o_scan_busy   = (r_state != S_IDLE);

  always_comb begin
    w_cnt_nxt = 4'd1;
    if (r_scan_buf == r_prev_scan) begin
      w_cnt_nxt = (r_stable_cnt >= STABLE_MAX) ? STABLE_MAX : r_stable_cnt + 4'd1;
    end
  end

  // Saturating count lets a publish blocked by an unread board fire on a later scan.
  assign w_publish = (w_cnt_nxt == STABLE_MAX) && !r_done &&
                     ((r_scan_buf != r_board_state) || r_first_pub);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_row         <= 3'd0;
      r_settle      <= '0;
      r_col_s1      <= 8'h00;
      r_col_s2      <= 8'h00;
      r_scan_buf    <= 64'h0;
      r_prev_scan   <= 64'h0;
      r_board_state <= 64'h0;
      r_stable_cnt  <= 4'd0;
      r_first_pub   <= 1'b1;
      r_done        <= 1'b0;
    end else begin
      r_col_s1 <= i_col_in;
      r_col_s2 <= r_col_s1;
      if (r_done && i_ack) begin
        r_done <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          r_row    <= 3'd0;
          r_settle <= '0;
          r_state  <= S_DRIVE;
        end
        S_DRIVE: begin
          if (r_settle == SETTLE_LAST) begin
            r_settle <= '0;
            r_state  <= S_SAMPLE;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_SAMPLE: begin
          r_scan_buf[{r_row, 3'b000} +: 8] <= r_col_s2;
          r_state <= S_NEXT;
        end
        S_NEXT: begin
          if (r_row == 3'd7) begin
            r_row   <= 3'd0;
            r_state <= S_COMPARE;
          end else begin
            r_row   <= r_row + 3'd1;
            r_state <= S_DRIVE;
          end
        end
        S_COMPARE: begin
          r_stable_cnt <= w_cnt_nxt;
          r_prev_scan  <= r_scan_buf;
          if (w_publish) begin
            r_board_state <= r_scan_buf;
            r_done        <= 1'b1;
            r_first_pub   <= 1'b0;
          end
          r_state <= S_DRIVE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
